run_length_detector: RTL and testbench
======================================

RUN_LENGTH_DETECTOR -- requirements
Module: run_length_detector

Interface
REQ-001 Parameters SHALL be: CHANNELS, default 4, number of independent serial inputs; RUN_LEN, default 5, consecutive-match count that constitutes a hit (legal range 1..255); HIT_CNT_W, default 8, width of the hit counter.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock  in  1  single rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  advance all channels this cycle; low = hold all state.
- x_in  in  CHANNELS  serial data bit per channel.
- match_val  in  1  bit value being counted (1 = runs of ones, 0 = runs of zeros).
- pulse_mode  in  1  0 = level output, 1 = single-cycle pulse output.
- clear_hits  in  1  synchronous clear of hit_count.
- y_out  out  CHANNELS  per-channel detect output.
- hit_count  out  HIT_CNT_W  total hits across all channels since reset or clear.

Function
REQ-003 Each channel SHALL hold a run counter cnt of width clog2(RUN_LEN+1).
REQ-004 On a clock edge with enable=1, cnt SHALL become min(cnt+1, RUN_LEN) when x_in[i]==match_val, else 0.
REQ-005 On a clock edge with enable=0, cnt, hit flags and hit_count SHALL hold, except for the REQ-008 pulse clear and the REQ-011 clear.
REQ-006 A crossing on channel i SHALL be a clock edge with enable=1 where cnt==RUN_LEN-1 and x_in[i]==match_val. Runs longer than RUN_LEN SHALL NOT produce further crossings until cnt returns to 0.
REQ-007 Level mode (pulse_mode=0): y_out[i] SHALL equal (cnt==RUN_LEN) as a Moore output, decoded from state only with no x_in path.
REQ-008 Pulse mode (pulse_mode=1): y_out[i] SHALL be a registered flag that is set by a crossing and cleared on the next clock edge, so it is high for exactly one cycle regardless of enable.
REQ-009 pulse_mode SHALL only select the output source. Changing it mid-run SHALL NOT alter cnt.
REQ-010 A change of match_val SHALL take effect at the next enabled edge. cnt SHALL NOT be cleared by the change itself.
REQ-011 On each edge, hit_count SHALL add the number of channels crossing that edge, saturating at 2^HIT_CNT_W-1. With clear_hits=1, the result SHALL be 0 and that edge's crossings SHALL be discarded (clear wins).
REQ-012 Simultaneous crossings on several channels in one cycle SHALL all be counted.
REQ-013 Latency SHALL be: y_out rises in the cycle after the edge that samples the RUN_LEN-th consecutive match, in both modes.
REQ-014 With RUN_LEN=1, a single matching sample at cnt=0 SHALL be a crossing.

Reset
REQ-015 While reset=1, all cnt, pulse flags, y_out and hit_count SHALL be 0, independent of clock.
REQ-016 Reset asserted mid-run SHALL abort the run. After release, a full RUN_LEN consecutive matches SHALL be needed for a hit.
REQ-017 The first enabled edge after reset release SHALL be evaluated normally, with no dropped sample.

Structure
REQ-018 A shared package SHALL hold the counter-width function and the default-parameter constants.
REQ-019 Per-channel logic (cnt, crossing detect, pulse flag, output mux) SHALL be a sub-module named run_channel, instantiated CHANNELS times by generate. The top level SHALL own only the crossing popcount and hit_count.

Verification (CHANNELS=4, RUN_LEN=5, HIT_CNT_W=8)
REQ-020 Level, match_val=1, ch0 inputs 1,1,1,1,1,1,0 -> y_out[0] high after the 5th edge and for the following cycle, low after the 0; hit_count=1.
REQ-021 Pulse mode, ch0 ten consecutive 1s -> y_out[0] high for exactly one cycle after the 5th edge; hit_count=1.
REQ-022 match_val=0, ch2 inputs 0,0,0,0,1,0,0,0,0,0 -> no hit at the 4th sample; hit after the 10th sample; hit_count=1.
REQ-023 All four channels reach their 5th match on the same edge -> hit_count increments by 4. Repeat with clear_hits=1 on that edge -> hit_count=0.
REQ-024 Three 1s, then enable=0 for 3 cycles (x_in=0), then two 1s -> hit after the 5th enabled match. Separately, reset pulsed after four 1s -> no hit until five more 1s.
REQ-025 Force 300 hits -> hit_count saturates at 255 and stays there.

Source files
------------

// File: rtl/run_length_detector_pkg.sv
// Shared constants and helpers for the run-length detector.
// Default parameters and the run-counter width function.
package run_length_detector_pkg;

    localparam int DEF_CHANNELS  = 4;
    localparam int DEF_RUN_LEN   = 5;
    localparam int DEF_HIT_CNT_W = 8;

    function automatic int cnt_width(input int run_len);
        return $clog2(run_len + 1);
    endfunction

endpackage

// File: rtl/run_length_detector_run_channel.sv
// One serial channel: saturating run counter, crossing detect,
// single-cycle pulse flag and level/pulse output select.
module run_channel
    import run_length_detector_pkg::*;
#(
    parameter int RUN_LEN = DEF_RUN_LEN
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic x_in,
    input  logic match_val,
    input  logic pulse_mode,
    output logic y_out,
    output logic crossing
);

    localparam int CW = cnt_width(RUN_LEN);
    localparam logic [CW-1:0] FULL = CW'(RUN_LEN);
    localparam logic [CW-1:0] LAST = CW'(RUN_LEN - 1);

    logic [CW-1:0] cnt;
    logic          pulse_q;
    logic          is_match;

    assign is_match = (x_in == match_val);
    assign crossing = enable && is_match && (cnt == LAST);

    // Pulse flag follows crossing every edge, so it self-clears
    // even while enable is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= crossing;
            if (enable) begin
                if (!is_match)
                    cnt <= '0;
                else if (cnt != FULL)
                    cnt <= cnt + CW'(1);
            end
        end
    end

    assign y_out = pulse_mode ? pulse_q : (cnt == FULL);

endmodule

// File: rtl/run_length_detector.sv
// Multi-channel run-length detector: per-channel detectors plus
// a saturating count of crossings across all channels.
module run_length_detector
    import run_length_detector_pkg::*;
#(
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int RUN_LEN   = DEF_RUN_LEN,
    parameter int HIT_CNT_W = DEF_HIT_CNT_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CHANNELS-1:0]  x_in,
    input  logic                 match_val,
    input  logic                 pulse_mode,
    input  logic                 clear_hits,
    output logic [CHANNELS-1:0]  y_out,
    output logic [HIT_CNT_W-1:0] hit_count
);

    localparam int PW = $clog2(CHANNELS + 1);
    localparam int SW = HIT_CNT_W + 1;
    localparam logic [SW-1:0] SAT = {1'b0, {HIT_CNT_W{1'b1}}};

    logic [CHANNELS-1:0] crossing;
    logic [PW-1:0]       n_cross;
    logic [SW-1:0]       sum;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        run_channel #(
            .RUN_LEN(RUN_LEN)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .enable    (enable),
            .x_in      (x_in[i]),
            .match_val (match_val),
            .pulse_mode(pulse_mode),
            .y_out     (y_out[i]),
            .crossing  (crossing[i])
        );
    end

    always_comb begin
        n_cross = '0;
        for (int i = 0; i < CHANNELS; i++)
            n_cross = n_cross + PW'(crossing[i]);
    end

    assign sum = {1'b0, hit_count} + SW'(n_cross);

    // Clear takes priority over any crossings on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            hit_count <= '0;
        else if (clear_hits)
            hit_count <= '0;
        else if (sum > SAT)
            hit_count <= '1;
        else
            hit_count <= sum[HIT_CNT_W-1:0];
    end

endmodule

// File: tb/tb_run_length_detector.sv
// Scoreboard bench for run_length_detector with a run-length
// reference model; directed scenarios followed by random traffic.
module tb_run_length_detector;

    localparam int CH   = 4;
    localparam int RL   = 5;
    localparam int HW   = 8;
    localparam int HMAX = 255;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [CH-1:0] x_in = '0;
    logic          match_val = 1'b1;
    logic          pulse_mode = 1'b0;
    logic          clear_hits = 1'b0;
    logic [CH-1:0] y_out;
    logic [HW-1:0] hit_count;

    always #5 clock = ~clock;

    run_length_detector #(
        .CHANNELS (CH),
        .RUN_LEN  (RL),
        .HIT_CNT_W(HW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .x_in      (x_in),
        .match_val (match_val),
        .pulse_mode(pulse_mode),
        .clear_hits(clear_hits),
        .y_out     (y_out),
        .hit_count (hit_count)
    );

    typedef struct packed {
        logic [CH-1:0] y;
        logic [HW-1:0] hit;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;

    // Reference state: length of the current matching run per channel
    // (unbounded) and the expected hit total.
    int run[CH];
    int m_hit = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d",
                     name, cycle, act, exp);
        end
    endtask

    task automatic drive(input logic [CH-1:0] x, input logic en,
                         input logic mv, input logic pm,
                         input logic clr);
        int   nc;
        exp_t e;
        @(negedge clock);
        reset = 1'b0;
        x_in = x;
        enable = en;
        match_val = mv;
        pulse_mode = pm;
        clear_hits = clr;
        nc = 0;
        e.y = '0;
        for (int i = 0; i < CH; i++) begin
            if (en) begin
                if (x[i] == mv) begin
                    if (run[i] + 1 == RL) begin
                        nc++;
                        e.y[i] = pm;
                    end
                    run[i] = run[i] + 1;
                end else begin
                    run[i] = 0;
                end
            end
            if (!pm)
                e.y[i] = (run[i] >= RL);
        end
        if (clr)
            m_hit = 0;
        else
            m_hit = (m_hit + nc > HMAX) ? HMAX : m_hit + nc;
        e.hit = m_hit[HW-1:0];
        sb.push_back(e);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clock);
        reset = 1'b1;
        enable = 1'b0;
        clear_hits = 1'b0;
        for (int i = 0; i < CH; i++)
            run[i] = 0;
        m_hit = 0;
        e.y = '0;
        e.hit = '0;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain cycle=%0d actual=%0d expected=0",
                     cycle, sb.size());
            sb.delete();
        end
    endtask

    task automatic ones(input logic [CH-1:0] x, input int n,
                        input logic pm);
        for (int k = 0; k < n; k++)
            drive(x, 1'b1, 1'b1, pm, 1'b0);
    endtask

    // Monitor: compares every clocked output against the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            cycle++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("y_out", int'(y_out), int'(e.y));
                check("hit_count", int'(hit_count), int'(e.hit));
            end
        end
    end

    initial begin : stim
        logic [CH-1:0] xr;
        logic          mv;
        logic          pm;
        logic [CH-1:0] z;
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++)
            run[i] = 0;

        // Level mode, ch0 runs of ones
        do_reset();
        ones(4'b0001, 6, 1'b0);
        drive(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

        // Pulse mode, ten ones
        do_reset();
        ones(4'b0001, 10, 1'b1);
        drive(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);

        // Runs of zeros on ch2, broken at the 5th sample
        do_reset();
        z = 4'b1011;
        for (int k = 0; k < 10; k++) begin
            v = z;
            v[2] = (k == 4);
            drive(v, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        drive(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);

        // All channels cross together, then again with clear
        do_reset();
        ones(4'b1111, 5, 1'b0);
        drive(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        ones(4'b1111, 4, 1'b1);
        drive(4'b1111, 1'b1, 1'b1, 1'b1, 1'b1);
        drive(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);

        // Enable gaps do not break a run
        do_reset();
        ones(4'b0001, 3, 1'b0);
        for (int k = 0; k < 3; k++)
            drive(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        ones(4'b0001, 3, 1'b0);

        // Reset mid-run aborts it
        do_reset();
        ones(4'b0001, 4, 1'b0);
        do_reset();
        ones(4'b0001, 4, 1'b0);
        ones(4'b0001, 2, 1'b1);

        // Saturation: 300 hits
        do_reset();
        for (int r = 0; r < 75; r++) begin
            ones(4'b1111, 5, r[0]);
            drive(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        ones(4'b1111, 12, 1'b0);
        wait_drain();
        @(negedge clock);
        check("saturated", int'(hit_count), HMAX);

        // Random traffic with mid-run mode and match changes
        do_reset();
        mv = 1'b1;
        pm = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(99) < 5)
                mv = ~mv;
            if ($urandom_range(99) < 10)
                pm = ~pm;
            for (int i = 0; i < CH; i++)
                xr[i] = ($urandom_range(99) < 85) ? mv : ~mv;
            if ($urandom_range(999) < 8)
                do_reset();
            else
                drive(xr, $urandom_range(99) < 85, mv, pm,
                      $urandom_range(99) < 2);
        end

        wait_drain();
        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
